tb_dinb_seq: RTL

TB_DINB_SEQ -- requirements
Module: tb_dinb_seq

---
 rtl/tb_dinb_seq_pkg.sv | 23 ++
 rtl/tb_dinb_seq_if.sv | 32 +++
 rtl/tb_dinb_addr_gen.sv | 62 ++++++
 rtl/tb_dinb_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tb_dinb_seq_pkg.sv
// Shared definitions for the TB port-B sequencer and the dinb mapper:
// direction encodings, FSM state encodings and a small direction helper.
package tb_dinb_seq_pkg;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_POS  = 2'b01,
      DIR_NEG  = 2'b10,
      DIR_NEW  = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DELAY  = 2'b01,
      ST_STREAM = 2'b10,
      ST_DRAIN  = 2'b11
   } state_e;

   function automatic logic dir_counts_down(input dir_e dir);
      return (dir == DIR_NEG);
   endfunction

endpackage

// File: rtl/tb_dinb_seq_if.sv
// Command handshake plus TB port-B / mapper control bundle of the sequencer.
interface tb_dinb_seq_if #(
   parameter int L     = 4,
   parameter int TB_AW = 10,
   parameter int LEN_W = 8,
   parameter int DLY_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_dir;
   logic             cmd_l_k_0;
   logic [TB_AW-1:0] cmd_base;
   logic [LEN_W-1:0] cmd_len;
   logic [DLY_W-1:0] cmd_dly;
   logic [1:0]       TB_dinb_sel;
   logic             l_k_0;
   logic             TB_enb;
   logic [L-1:0]     TB_web;
   logic [TB_AW-1:0] TB_addrb;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, cmd_dir, cmd_l_k_0, cmd_base, cmd_len, cmd_dly,
      input  cmd_ready, TB_dinb_sel, l_k_0, TB_enb, TB_web, TB_addrb, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_l_k_0, cmd_base, cmd_len, cmd_dly,
      output cmd_ready, TB_dinb_sel, l_k_0, TB_enb, TB_web, TB_addrb, busy, done
   );
endinterface

// File: rtl/tb_dinb_addr_gen.sv
// Beat address generator: loads the base on command acceptance, steps +/-1
// per streamed beat and derives the per-lane write-enable pattern.
module tb_dinb_addr_gen
   import tb_dinb_seq_pkg::*;
#(
   parameter int X     = 4,
   parameter int L     = 4,
   parameter int TB_AW = 10
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic             load_i,
   input  logic [TB_AW-1:0] base_i,
   input  dir_e             dir_i,
   input  logic             l_k_0_i,
   input  logic             step_i,
   output logic [TB_AW-1:0] addr_o,
   output logic [L-1:0]     web_o
);

   logic [TB_AW-1:0] addr_q;
   dir_e             dir_q;
   logic             lk0_q;
   logic [L-1:0]     web_s;

   // Current beat address; wraps modulo 2^TB_AW in either direction
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         addr_q <= '0;
         dir_q  <= DIR_IDLE;
         lk0_q  <= 1'b0;
      end else if (load_i) begin
         addr_q <= base_i;
         dir_q  <= dir_i;
         lk0_q  <= l_k_0_i;
      end else if (step_i) begin
         if (dir_counts_down(dir_q)) begin
            addr_q <= addr_q - TB_AW'(1);
         end else begin
            addr_q <= addr_q + TB_AW'(1);
         end
      end else begin
         addr_q <= addr_q;
      end
   end

   // Lane enables: only lanes fed by the RSA for POS/NEG, one half for NEW
   always_comb begin
      web_s = '0;
      for (int i = 0; i < L; i++) begin
         case (dir_q)
            DIR_POS, DIR_NEG: web_s[i] = (i < X);
            DIR_NEW:          web_s[i] = lk0_q ? (i < L / 2) : (i >= L / 2);
            default:          web_s[i] = 1'b0;
         endcase
      end
   end

   assign addr_o = addr_q;
   assign web_o  = web_s;

endmodule

// File: rtl/tb_dinb_seq.sv
// TB port-B write sequencer: IDLE -> DELAY -> STREAM -> DRAIN with writes
// trailing the mapper select by one cycle. Optional TB_DINB_SEQ_PERF_CNT_EN adds perf_cmd_cnt.
module tb_dinb_seq
   import tb_dinb_seq_pkg::*;
#(
   parameter int X     = 4,
   parameter int L     = 4,
   parameter int TB_AW = 10,
   parameter int LEN_W = 8,
   parameter int DLY_W = 4
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   tb_dinb_seq_if.slave  bus
`ifdef TB_DINB_SEQ_PERF_CNT_EN
   ,
   output logic [15:0]   perf_cmd_cnt
`endif
);

   state_e           state_q;
   logic [DLY_W-1:0] dly_cnt_q;
   logic [LEN_W-1:0] len_cnt_q;
   dir_e             dir_q;
   logic             lk0_q;
   logic             cmd_ready_q;
   logic [1:0]       sel_q;
   logic             lk0_out_q;
   logic             enb_q;
   logic [L-1:0]     web_q;
   logic [TB_AW-1:0] addrb_q;
   logic             busy_q;
   logic             done_q;
   logic             accept_s;
   logic             stream_s;
   logic [LEN_W-1:0] len_eff_s;
   logic [TB_AW-1:0] beat_addr_s;
   logic [L-1:0]     beat_web_s;

   assign accept_s  = (state_q == ST_IDLE) && bus.cmd_valid;
   assign stream_s  = (state_q == ST_STREAM);
   // A null direction carries no data, so it behaves as a zero-length command
   assign len_eff_s = (bus.cmd_dir == DIR_IDLE) ? '0 : bus.cmd_len;

   tb_dinb_addr_gen #(.X(X), .L(L), .TB_AW(TB_AW)) u_addr_gen (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .load_i    (accept_s),
      .base_i    (bus.cmd_base),
      .dir_i     (dir_e'(bus.cmd_dir)),
      .l_k_0_i   (bus.cmd_l_k_0),
      .step_i    (stream_s),
      .addr_o    (beat_addr_s),
      .web_o     (beat_web_s)
   );

   // Control FSM with registered outputs; the write strobe trails STREAM by one cycle
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         dly_cnt_q   <= '0;
         len_cnt_q   <= '0;
         dir_q       <= DIR_IDLE;
         lk0_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         sel_q       <= 2'b00;
         lk0_out_q   <= 1'b0;
         enb_q       <= 1'b0;
         web_q       <= '0;
         addrb_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         enb_q  <= stream_s;
         web_q  <= stream_s ? beat_web_s : '0;
         if (stream_s) begin
            addrb_q <= beat_addr_s;
         end else begin
            addrb_q <= addrb_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  dir_q       <= dir_e'(bus.cmd_dir);
                  lk0_q       <= bus.cmd_l_k_0;
                  dly_cnt_q   <= bus.cmd_dly;
                  len_cnt_q   <= len_eff_s;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_dly != '0) begin
                     state_q <= ST_DELAY;
                  end else if (len_eff_s != '0) begin
                     state_q   <= ST_STREAM;
                     sel_q     <= bus.cmd_dir;
                     lk0_out_q <= bus.cmd_l_k_0;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DELAY: begin
               if (dly_cnt_q == DLY_W'(1)) begin
                  if (len_cnt_q != '0) begin
                     state_q   <= ST_STREAM;
                     sel_q     <= dir_q;
                     lk0_out_q <= lk0_q;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  dly_cnt_q <= dly_cnt_q - DLY_W'(1);
               end
            end
            ST_STREAM: begin
               if (len_cnt_q == LEN_W'(1)) begin
                  state_q   <= ST_DRAIN;
                  sel_q     <= 2'b00;
                  lk0_out_q <= 1'b0;
               end else begin
                  len_cnt_q <= len_cnt_q - LEN_W'(1);
               end
            end
            ST_DRAIN: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               sel_q       <= 2'b00;
               lk0_out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.TB_dinb_sel = sel_q;
   assign bus.l_k_0       = lk0_out_q;
   assign bus.TB_enb      = enb_q;
   assign bus.TB_web      = web_q;
   assign bus.TB_addrb    = addrb_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

`ifdef TB_DINB_SEQ_PERF_CNT_EN
   logic [15:0] perf_cnt_q;

   // Completed-command counter, stepping on the same edge that raises done
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         perf_cnt_q <= 16'h0000;
      end else if (state_q == ST_DRAIN) begin
         perf_cnt_q <= perf_cnt_q + 16'h0001;
      end else begin
         perf_cnt_q <= perf_cnt_q;
      end
   end

   assign perf_cmd_cnt = perf_cnt_q;
`endif

endmodule
